// File: rtl/riscv_fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, issues word reads over req/ack and buffers {pc, word} in a FIFO.
// Optional RISCV_FETCH_MISALIGN_CHECK_EN: misaligned redirects halt fetch and raise a sticky flag.
module riscv_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        clk_i,
    input  logic        reset_n_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_rdata_i,
    output logic        inst_valid_o,
    input  logic        inst_ready_i,
    output logic [31:0] inst_data_o,
    output logic [31:0] inst_pc_o,
    input  logic        redirect_valid_i,
    input  logic [31:0] redirect_pc_i,
    output logic        fetch_misaligned_o
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

`ifdef RISCV_FETCH_MISALIGN_CHECK_EN
    typedef enum logic [1:0] {S_BOOT, S_RUN, S_HALT} state_e;
`else
    typedef enum logic [1:0] {S_BOOT, S_RUN} state_e;
`endif

    state_e          state_q, state_d;
    logic [31:0]     fetch_pc_q, fetch_pc_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [31:0]     pc_mem_q   [FIFO_DEPTH];
    logic [31:0]     data_mem_q [FIFO_DEPTH];
    logic            xfer, pop, misaligned_rd;

`ifdef RISCV_FETCH_MISALIGN_CHECK_EN
    assign misaligned_rd = redirect_valid_i && (redirect_pc_i[1:0] != 2'b00);
`else
    // Low redirect bits are discarded when the check is compiled out.
    logic unused_pc_lsbs;
    assign unused_pc_lsbs = ^redirect_pc_i[1:0];
    assign misaligned_rd  = 1'b0;
`endif

    // State register
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) state_q <= S_BOOT;
        else            state_q <= state_d;
    end

    // Next-state logic: redirect overrides everything, including BOOT
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_BOOT:  state_d = S_RUN;
            default: state_d = state_q;
        endcase
        if (redirect_valid_i) begin
            state_d = S_RUN;
`ifdef RISCV_FETCH_MISALIGN_CHECK_EN
            if (misaligned_rd) state_d = S_HALT;
`endif
        end
    end

    // Output logic
    always_comb begin
        imem_req_o  = (state_q == S_RUN) && (count_q < CW'(FIFO_DEPTH)) && !redirect_valid_i;
        imem_addr_o = fetch_pc_q;
    end

    assign xfer         = imem_req_o && imem_ack_i;
    assign inst_valid_o = (count_q != '0);
    assign pop          = inst_valid_o && inst_ready_i;
    assign inst_data_o  = data_mem_q[rd_ptr_q];
    assign inst_pc_o    = pc_mem_q[rd_ptr_q];

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        if (redirect_valid_i) begin
            fetch_pc_d = {redirect_pc_i[31:2], 2'b00};
            rd_ptr_d   = wr_ptr_q;
            count_d    = '0;
        end else begin
            if (xfer) begin
                fetch_pc_d = fetch_pc_q + 32'd4;
                wr_ptr_d   = wr_ptr_q + AW'(1);
            end
            if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
            if (xfer && !pop)      count_d = count_q + CW'(1);
            else if (pop && !xfer) count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            fetch_pc_q <= RESET_PC;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                pc_mem_q[i]   <= '0;
                data_mem_q[i] <= '0;
            end
        end else begin
            fetch_pc_q <= fetch_pc_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            // Storage write is harmless on redirect: the entry lies outside the flushed window.
            if (xfer) begin
                pc_mem_q[wr_ptr_q]   <= fetch_pc_q;
                data_mem_q[wr_ptr_q] <= imem_rdata_i;
            end
        end
    end

`ifdef RISCV_FETCH_MISALIGN_CHECK_EN
    logic mis_q;
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i)            mis_q <= 1'b0;
        else if (redirect_valid_i) mis_q <= misaligned_rd;
    end
    assign fetch_misaligned_o = mis_q;
`else
    assign fetch_misaligned_o = 1'b0;
`endif

endmodule

// File: tb/tb_riscv_fetch_unit.sv
// Bench for riscv_fetch_unit: directed vector table, wrap sequence, then random traffic against a queue model.
module tb_riscv_fetch_unit;

`ifdef RISCV_FETCH_MISALIGN_CHECK_EN
    localparam bit MIS = 1'b1;
`else
    localparam bit MIS = 1'b0;
`endif
    localparam logic [31:0] K = 32'hA5A5_5A5A;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        imem_req, imem_ack = 1'b0, inst_valid, inst_ready = 1'b0;
    logic        redirect_valid = 1'b0, fetch_misaligned;
    logic [31:0] imem_addr, imem_rdata = '0, inst_data, inst_pc, redirect_pc = '0;

    riscv_fetch_unit dut (
        .clk_i(clk), .reset_n_i(reset_n),
        .imem_req_o(imem_req), .imem_addr_o(imem_addr),
        .imem_ack_i(imem_ack), .imem_rdata_i(imem_rdata),
        .inst_valid_o(inst_valid), .inst_ready_i(inst_ready),
        .inst_data_o(inst_data), .inst_pc_o(inst_pc),
        .redirect_valid_i(redirect_valid), .redirect_pc_i(redirect_pc),
        .fetch_misaligned_o(fetch_misaligned)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        bit          ack, rdy, rv;
        logic [31:0] rpc;
        bit          e_req;
        logic [31:0] e_addr;
        bit          e_vld;
        logic [31:0] e_pc;
        bit          e_mis;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(bit a, bit r, bit rv, logic [31:0] rpc, bit req,
                                logic [31:0] addr, bit vld, logic [31:0] pc, bit mis);
        vec_t v;
        v.ack = a; v.rdy = r; v.rv = rv; v.rpc = rpc; v.e_req = req;
        v.e_addr = addr; v.e_vld = vld; v.e_pc = pc; v.e_mis = mis;
        return v;
    endfunction

    // Reference model state
    typedef struct { logic [31:0] pc; logic [31:0] data; } ent_t;
    ent_t        mq[$];
    bit          m_boot, m_halt, m_mis;
    logic [31:0] m_pc;

    task automatic model_reset();
        mq.delete(); m_boot = 1'b0; m_halt = 1'b0; m_mis = 1'b0; m_pc = 32'h0;
    endtask

    task automatic model_check_and_step();
        bit   e_req;
        ent_t e;
        e_req = m_boot && !m_halt && (mq.size() < 4) && !redirect_valid;
        chk("req", 32'(imem_req), 32'(e_req));
        chk("addr", imem_addr, m_pc);
        chk("valid", 32'(inst_valid), 32'(mq.size() != 0));
        if (mq.size() != 0) begin
            chk("pc", inst_pc, mq[0].pc);
            chk("data", inst_data, mq[0].data);
        end
        chk("mis", 32'(fetch_misaligned), 32'(m_mis));
        if (redirect_valid) begin
            mq.delete();
            m_pc = {redirect_pc[31:2], 2'b00};
            if (MIS) begin
                m_mis  = (redirect_pc[1:0] != 2'b00);
                m_halt = m_mis;
            end
        end else begin
            if (mq.size() != 0 && inst_ready) void'(mq.pop_front());
            if (e_req && imem_ack) begin
                e.pc = m_pc; e.data = imem_rdata;
                mq.push_back(e);
                m_pc = m_pc + 32'd4;
            end
        end
        m_boot = 1'b1;
    endtask

    initial begin
        // Directed table, starting from the BOOT cycle
        vt.push_back(mk(1,0,0,0,      0,32'h0,  0,0,0));
        vt.push_back(mk(1,0,0,0,      1,32'h0,  0,0,0));
        vt.push_back(mk(1,0,0,0,      1,32'h4,  1,32'h0,0));
        vt.push_back(mk(1,0,0,0,      1,32'h8,  1,32'h0,0));
        vt.push_back(mk(1,0,0,0,      1,32'hC,  1,32'h0,0));
        vt.push_back(mk(1,1,0,0,      0,32'h10, 1,32'h0,0));
        vt.push_back(mk(0,0,0,0,      1,32'h10, 1,32'h4,0));
        vt.push_back(mk(0,0,0,0,      1,32'h10, 1,32'h4,0));
        vt.push_back(mk(1,0,0,0,      1,32'h10, 1,32'h4,0));
        vt.push_back(mk(1,1,1,32'h100,0,32'h14, 1,32'h4,0));
        vt.push_back(mk(1,1,0,0,      1,32'h100,0,0,0));
        vt.push_back(mk(1,1,0,0,      1,32'h104,1,32'h100,0));
        vt.push_back(mk(0,0,1,32'h102,0,32'h108,1,32'h104,0));
        vt.push_back(mk(1,0,0,0,      !MIS,32'h100,0,0,MIS));
        vt.push_back(mk(1,0,0,0,      !MIS,MIS ? 32'h100 : 32'h104,!MIS,32'h100,MIS));
        vt.push_back(mk(1,0,1,32'h200,0,MIS ? 32'h100 : 32'h108,!MIS,32'h100,MIS));
        vt.push_back(mk(1,1,0,0,      1,32'h200,0,0,0));
        vt.push_back(mk(1,1,0,0,      1,32'h204,1,32'h200,0));

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req", 32'(imem_req), 32'h0);
        chk("rst_valid", 32'(inst_valid), 32'h0);
        chk("rst_data", inst_data, 32'h0);
        chk("rst_pc", inst_pc, 32'h0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_mis", 32'(fetch_misaligned), 32'h0);
        reset_n = 1'b1;

        foreach (vt[i]) begin
            imem_ack = vt[i].ack; inst_ready = vt[i].rdy;
            redirect_valid = vt[i].rv; redirect_pc = vt[i].rpc;
            imem_rdata = vt[i].e_addr ^ K;
            #1;
            chk($sformatf("v%0d_req", i), 32'(imem_req), 32'(vt[i].e_req));
            chk($sformatf("v%0d_addr", i), imem_addr, vt[i].e_addr);
            chk($sformatf("v%0d_valid", i), 32'(inst_valid), 32'(vt[i].e_vld));
            if (vt[i].e_vld) begin
                chk($sformatf("v%0d_pc", i), inst_pc, vt[i].e_pc);
                chk($sformatf("v%0d_data", i), inst_data, vt[i].e_pc ^ K);
            end
            chk($sformatf("v%0d_mis", i), 32'(fetch_misaligned), 32'(vt[i].e_mis));
            @(negedge clk);
        end

        // Address wrap at the top of the 32-bit space
        imem_ack = 1'b1; inst_ready = 1'b0;
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        @(negedge clk);
        redirect_valid = 1'b0; imem_rdata = 32'h1234_5678;
        #1;
        chk("wrap_req", 32'(imem_req), 32'h1);
        chk("wrap_addr0", imem_addr, 32'hFFFF_FFFC);
        @(negedge clk);
        #1;
        chk("wrap_addr1", imem_addr, 32'h0);
        chk("wrap_valid", 32'(inst_valid), 32'h1);
        chk("wrap_pc", inst_pc, 32'hFFFF_FFFC);
        chk("wrap_data", inst_data, 32'h1234_5678);

        // Randomized traffic against the queue model, with one mid-run async reset
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();
        for (int c = 0; c < 2000; c++) begin
            imem_ack       = ($urandom_range(3) != 0);
            inst_ready     = ($urandom_range(2) != 0);
            redirect_valid = ($urandom_range(15) == 0);
            redirect_pc    = $urandom();
            if ($urandom_range(3) != 0) redirect_pc[1:0] = 2'b00;
            if ($urandom_range(7) == 0) redirect_pc = 32'hFFFF_FFF0 | (redirect_pc & 32'hF);
            imem_rdata     = $urandom();
            #1;
            model_check_and_step();
            if (c == 1000) begin
                reset_n = 1'b0;
                #1;
                chk("mid_rst_req", 32'(imem_req), 32'h0);
                chk("mid_rst_valid", 32'(inst_valid), 32'h0);
                chk("mid_rst_addr", imem_addr, 32'h0);
                chk("mid_rst_data", inst_data, 32'h0);
                chk("mid_rst_pc", inst_pc, 32'h0);
                chk("mid_rst_mis", 32'(fetch_misaligned), 32'h0);
                model_reset();
                @(negedge clk);
                reset_n = 1'b1;
            end else begin
                @(negedge clk);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
